// File: rtl/io_seg_mux.sv
// io_seg_mux: scans a 4-digit, 7-segment display from a 16-bit hex value.
// The inputs are captured on load into a pending shadow register. That data
// moves into the active register only at a frame boundary, so a frame never
// shows a partially updated value.
// Optional feature: define IO_SEG_MUX_LZB_EN to enable leading-zero blanking
// of digits 3..1.
module io_seg_mux #(
  parameter int DIV_W     = 16,
  parameter int BLANK_CYC = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] value,
  input  logic [3:0]  dp,
  input  logic [3:0]  blank,
  input  logic        load,
  output logic [3:0]  io_sel,
  output logic [7:0]  io_seg,
  output logic        frame_done
);

  localparam logic [DIV_W-1:0] BLANK_LIM = DIV_W'(BLANK_CYC);

  logic [DIV_W-1:0] cnt;
  logic [1:0]       digit;
  logic [15:0]      pend_value, act_value;
  logic [3:0]       pend_dp, pend_blank, act_dp, act_blank;
  logic             pend_vld;
  logic             boundary;
  logic [3:0]       nib;
  logic [6:0]       seg7;
  logic [3:0]       lz;
  logic             dark;
  logic [3:0]       sel_d;
  logic [7:0]       seg_d;

  assign boundary = (&cnt) && (digit == 2'd3);
  assign nib      = act_value[{digit, 2'b00} +: 4];

  // Scan prescaler; the digit advances each time the prescaler wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      digit <= 2'd0;
    end else begin
      cnt <= cnt + 1'b1;
      if (&cnt) digit <= digit + 2'd1;
    end
  end

  // Shadow/active registers. A load on the boundary cycle goes straight to
  // the active register and discards any older pending data.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_value <= '0;
      pend_dp    <= '0;
      pend_blank <= '0;
      pend_vld   <= 1'b0;
      act_value  <= '0;
      act_dp     <= '0;
      act_blank  <= '0;
    end else if (boundary) begin
      pend_vld <= 1'b0;
      if (load) begin
        act_value <= value;
        act_dp    <= dp;
        act_blank <= blank;
      end else if (pend_vld) begin
        act_value <= pend_value;
        act_dp    <= pend_dp;
        act_blank <= pend_blank;
      end
    end else if (load) begin
      pend_value <= value;
      pend_dp    <= dp;
      pend_blank <= blank;
      pend_vld   <= 1'b1;
    end
  end

  // Hex-to-segment decode, blanking and digit selection for the current slot.
  always_comb begin
    seg7 = 7'h00;
    case (nib)
      4'h0: seg7 = 7'h3F;
      4'h1: seg7 = 7'h06;
      4'h2: seg7 = 7'h5B;
      4'h3: seg7 = 7'h4F;
      4'h4: seg7 = 7'h66;
      4'h5: seg7 = 7'h6D;
      4'h6: seg7 = 7'h7D;
      4'h7: seg7 = 7'h07;
      4'h8: seg7 = 7'h7F;
      4'h9: seg7 = 7'h6F;
      4'hA: seg7 = 7'h77;
      4'hB: seg7 = 7'h7C;
      4'hC: seg7 = 7'h39;
      4'hD: seg7 = 7'h5E;
      4'hE: seg7 = 7'h79;
      4'hF: seg7 = 7'h71;
      default: seg7 = 7'h00;
    endcase

`ifdef IO_SEG_MUX_LZB_EN
    lz[3] = (act_value[15:12] == 4'h0);
    lz[2] = lz[3] && (act_value[11:8] == 4'h0);
    lz[1] = lz[2] && (act_value[7:4] == 4'h0);
    lz[0] = 1'b0;
`else
    lz = 4'h0;
`endif

    dark = (cnt < BLANK_LIM) || act_blank[digit] || lz[digit];
    if (dark) begin
      sel_d = 4'hF;
      seg_d = 8'hFF;
    end else begin
      sel_d = ~(4'b0001 << digit);
      seg_d = ~{act_dp[digit], seg7};
    end
  end

  // Registered outputs, one cycle behind the scan state.
  always_ff @(posedge clk) begin
    if (rst) begin
      io_sel     <= 4'hF;
      io_seg     <= 8'hFF;
      frame_done <= 1'b0;
    end else begin
      io_sel     <= sel_d;
      io_seg     <= seg_d;
      frame_done <= boundary;
    end
  end

endmodule

// File: tb/tb_io_seg_mux.sv
// tb_io_seg_mux: scoreboard bench for io_seg_mux with DIV_W=4, BLANK_CYC=2.
// The driver pushes the expected outputs of every cycle into a queue. A
// negedge monitor pops each entry and compares it with the DUT outputs.
module tb_io_seg_mux;
  localparam int DIV_W     = 4;
  localparam int BLANK_CYC = 2;
  localparam int SLOT      = 16;
  localparam int FRAME     = 64;

  logic        clk = 1'b0;
  logic        rst, load;
  logic [15:0] value;
  logic [3:0]  dp, blank;
  logic [3:0]  io_sel;
  logic [7:0]  io_seg;
  logic        frame_done;

  io_seg_mux #(.DIV_W(DIV_W), .BLANK_CYC(BLANK_CYC)) dut (
    .clk(clk), .rst(rst), .value(value), .dp(dp), .blank(blank), .load(load),
    .io_sel(io_sel), .io_seg(io_seg), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] sel;
    logic [7:0] seg;
    logic       fd;
  } exp_t;

  exp_t sb_q[$];
  exp_t exp_nxt;
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;

  // Model: cycle index since reset release, active data, pending data.
  int          t;
  logic [15:0] m_val, m_pval;
  logic [3:0]  m_dp, m_pdp, m_bl, m_pbl;
  logic        m_pend;

  logic [7:0] seg_tab [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                               8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

  // Display outputs that cycle tt's state produces, from the position in the frame.
  function automatic exp_t model_out(int tt, logic [15:0] v, logic [3:0] d, logic [3:0] b);
    exp_t       e;
    int         dig = (tt / SLOT) % 4;
    int         pos = tt % SLOT;
    int         hi  = 0;
    logic [3:0] nib;
    logic       drk;
    nib = 4'(v >> (4 * dig));
    for (int i = 0; i < 4; i++)
      if (4'(v >> (4 * i)) != 4'h0) hi = i;
    drk = (pos < BLANK_CYC) || b[dig];
`ifdef IO_SEG_MUX_LZB_EN
    if (dig > hi) drk = 1'b1;
`endif
    e.fd = ((tt % FRAME) == FRAME - 1);
    if (drk) begin
      e.sel = 4'hF;
      e.seg = 8'hFF;
    end else begin
      e.sel = ~(4'(1 << dig));
      e.seg = ~{d[dig], seg_tab[nib][6:0]};
    end
    return e;
  endfunction

  // One clock cycle: expect, drive, advance the model.
  task automatic step(input logic r, input logic ld, input logic [15:0] v,
                      input logic [3:0] d, input logic [3:0] b);
    sb_q.push_back(exp_nxt);
    rst = r; load = ld; value = v; dp = d; blank = b;
    if (r) begin
      exp_nxt = '{4'hF, 8'hFF, 1'b0};
      t = 0; m_val = '0; m_dp = '0; m_bl = '0; m_pend = 1'b0;
    end else begin
      exp_nxt = model_out(t, m_val, m_dp, m_bl);
      if ((t % FRAME) == FRAME - 1) begin
        if (ld) begin
          m_val = v; m_dp = d; m_bl = b;
        end else if (m_pend) begin
          m_val = m_pval; m_dp = m_pdp; m_bl = m_pbl;
        end
        m_pend = 1'b0;
      end else if (ld) begin
        m_pval = v; m_pdp = d; m_pbl = b; m_pend = 1'b1;
      end
      t++;
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      step(1'b0, 1'b0, 16'($urandom), 4'($urandom), 4'($urandom));
  endtask

  task automatic load_val(input logic [15:0] v, input logic [3:0] d, input logic [3:0] b);
    step(1'b0, 1'b1, v, d, b);
  endtask

  // Monitor: compare every cycle's outputs against the scoreboard.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      n_cmp++;
      if (io_sel !== mon_e.sel || io_seg !== mon_e.seg || frame_done !== mon_e.fd) begin
        n_bad++;
        $display("FAIL scan_out @%0t: got sel=%h seg=%h fd=%b, want sel=%h seg=%h fd=%b",
                 $time, io_sel, io_seg, frame_done, mon_e.sel, mon_e.seg, mon_e.fd);
      end
      n_cmp++;
      if ($countones(~io_sel) > 1) begin
        n_bad++;
        $display("FAIL sel_onehot @%0t: got sel=%h, want at most one low bit", $time, io_sel);
      end
    end
  end

  initial begin
    rst = 1'b1; load = 1'b0; value = '0; dp = '0; blank = '0;
    t = 0; m_val = '0; m_dp = '0; m_bl = '0; m_pend = 1'b0;
    m_pval = '0; m_pdp = '0; m_pbl = '0;
    exp_nxt = '{4'hF, 8'hFF, 1'b0};
    @(posedge clk); #1;

    repeat (3) step(1'b1, 1'b0, 16'($urandom), 4'($urandom), 4'($urandom));
    idle(5);

    load_val(16'h1234, 4'b0010, 4'h0);
    idle(150);

    while ((t % FRAME) != 5) idle(1);
    load_val(16'hAAAA, 4'h0, 4'h0);
    idle(70);
    while ((t % FRAME) != 30) idle(1);
    load_val(16'h5555, 4'h0, 4'h0);
    idle(140);

    load_val(16'h1111, 4'hF, 4'h0);
    while ((t % FRAME) != FRAME - 1) idle(1);
    load_val(16'hF00D, 4'h0, 4'h0);
    idle(70);

    load_val(16'h8888, 4'h0, 4'b1000);
    idle(140);

    load_val(16'h0040, 4'h0, 4'h0);
    idle(140);

    load_val(16'h0000, 4'h0, 4'h0);
    idle(140);

    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(0, 399) == 0), ($urandom_range(0, 19) == 0),
           16'($urandom), 4'($urandom),
           ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0);
    end
    idle(140);

    @(negedge clk); #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/io_seg_mux.md
# io_seg_mux

- Multiplexed driver for the IO board's 4-digit, 7-segment display.
- Takes a 16-bit hex value plus per-digit decimal-point and blank masks and scans the digits in turn.
- Drives the active-low `io_sel` digit enables and `io_seg` segment lines.
- Sits beside the LED PWM array in the board top level, which replaces its constant `io_sel`/`io_seg` assignments with this block's outputs.

## Interface

**Parameters**
- `DIV_W`, default 16: width of the scan prescaler. One digit slot lasts 2^DIV_W cycles.
- `BLANK_CYC`, default 256: cycles at the start of each slot with all digits off (anti-ghosting). Must be less than 2^DIV_W.

**Ports**
- `clk` in, 1: system clock. Single clock domain.
- `rst` in, 1: reset, synchronous, active-high.
- `value` in, 16: hex digits. `[3:0]` is digit 0 (rightmost) through `[15:12]` for digit 3.
- `dp` in, 4: decimal-point enable per digit. 1 = lit.
- `blank` in, 4: force a digit dark. 1 = dark.
- `load` in, 1: one-cycle strobe that captures `value`, `dp` and `blank`.
- `io_sel` out, 4: digit enables, active-low. Bit n selects digit n.
- `io_seg` out, 8: segments, active-low, ordered `{dp,g,f,e,d,c,b,a}`.
- `frame_done` out, 1: one-cycle pulse at each frame boundary.

## Operation

**Shadow registers**
- `load` captures the inputs into a pending register and sets a pending flag.
- A `load` while pending is already set overwrites the pending data; the last load wins.

**Scan counter**
- `cnt` (DIV_W bits) increments every cycle.
- When `cnt` wraps from all-ones to 0, `digit` advances 0→1→2→3→0.

**Frame boundary**
- A frame boundary is the cycle where `cnt` wraps and `digit` == 3.
- On that cycle:
  - If pending is set, the pending data copies into the active register and pending clears.
  - `frame_done` pulses.
- The display never shows a value partially updated mid-frame.
- If `load` coincides with a frame-boundary cycle, the newly loaded data goes straight to the active register, any older pending data is discarded, and pending is left clear.

**Decode**
- Hex nibble to active-high segments, `{g..a}`:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
- Bit 7 is the `dp` bit for the current digit.
- The whole byte is inverted onto `io_seg`.

**Selection**
- If `cnt` < `BLANK_CYC`, or active `blank[digit]` = 1: `io_sel` = 4'hF and `io_seg` = 8'hFF.
- Otherwise: `io_sel` = ~(1<<digit), and `io_seg` is the decoded active digit.

## Timing

- **Reset values:** `io_sel`=4'hF, `io_seg`=8'hFF, `frame_done`=0, `cnt`=0, `digit`=0. The active register is cleared (value 0, dp 0, blank 4'h0) and pending is cleared.
- **Output latency:** `io_sel`, `io_seg` and `frame_done` are registered, one cycle behind the `cnt`/`digit` state that produced them.
- **Frame length:** 4·2^DIV_W cycles.
- **First boundary after reset:** `frame_done` is first high on cycle 4·2^DIV_W after reset deassertion, counting cycle 0 as the first cycle with `rst` low.
- **Load to display:** loaded data appears on the display at the first digit-0 slot after the next frame boundary. Worst case is 4·2^DIV_W + 1 cycles after `load`.
- **Reset mid-frame:** reset asserted at any point returns all state to reset values on the next edge. Pending data is lost.
- **Illegal drive:** `io_sel` never has more than one bit low in any cycle.

## Configuration

- Macro: `IO_SEG_MUX_LZB_EN` (leading-zero blanking).
- **Defined:** digits 3, 2, 1 are blanked when their active nibble is 0 and every higher digit is also 0 or blanked by this rule. Blanked digits drive `io_sel`=4'hF and `io_seg`=8'hFF for the slot. Digit 0 is never blanked by this rule. The explicit `blank` mask still applies independently.
- **Undefined:** all four digits always display, including leading zeros.

## Test plan

All scenarios run with `DIV_W`=4 and `BLANK_CYC`=2.

1. **Reset:** hold `rst` for 3 cycles → `io_sel`=F, `io_seg`=FF, `frame_done`=0; first `frame_done` pulse occurs 64 cycles after release.
2. **Load 0x1234, dp=4'b0010:**
   - After the next boundary, the digit-0 slot shows `io_sel`=E, `io_seg`=99.
   - The digit-1 slot shows `io_sel`=D, `io_seg`=30 (3 with dp lit).
   - Cycles 0–1 of every slot show `io_sel`=F.
3. **Anti-tearing:** `load` 0xAAAA, then `load` 0x5555 mid-frame → the frame in progress keeps its old value; the next frame shows 0x5555 only, with digit 0 showing `io_seg`=92.
4. **Load on boundary:** assert `load` 0xF00D exactly on a frame-boundary cycle → the very next frame shows F00D, not stale data.
5. **Blank mask:** `blank`=4'b1000 with value 0x8888 → the digit-3 slot shows `io_sel`=F, `io_seg`=FF; other digits show `io_seg`=80.
6. **Leading-zero blanking:** value 0x0040 → with `IO_SEG_MUX_LZB_EN`, digits 3 and 2 are dark and digits 1 and 0 show 4 and 0; without the macro, digits 3, 2 and 0 show `io_seg`=C0.
